// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
// No logic; opcode 8 is legal only when SEQ_ALU_MUL_EN is defined.
// No flow control of its own.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_NOT  = 4'd2,
        OP_NOR  = 4'd3,
        OP_NAND = 4'd4,
        OP_XOR  = 4'd5,
        OP_ADD  = 4'd6,
        OP_SUB  = 4'd7,
        OP_MUL  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd8;

endpackage

// File: rtl/alu_shift_mul.sv
// Shift-and-add multiplier owning the accumulator and bit counter.
// Latency: start at edge k, done high in the cycle before edge k+WIDTH; product is final then.
// No backpressure: the caller must capture product in the done cycle.
module alu_shift_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q, addend;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // product already includes the current bit so the last step can be registered directly
    assign addend  = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    assign product = acc_q + addend;
    assign done    = busy_q && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= product;
            cnt_q <= cnt_q + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu_gates.sv
// Two-input and inverter gate cells used to build the bitwise logic ops.
// Purely combinational, zero latency.
// No flow control.
module gate_and2 (input logic a, input logic b, output logic y);
    assign y = a & b;
endmodule

module gate_or2 (input logic a, input logic b, output logic y);
    assign y = a | b;
endmodule

module gate_not1 (input logic a, output logic y);
    assign y = ~a;
endmodule

module gate_nor2 (input logic a, input logic b, output logic y);
    assign y = ~(a | b);
endmodule

module gate_nand2 (input logic a, input logic b, output logic y);
    assign y = ~(a & b);
endmodule

module gate_xor2 (input logic a, input logic b, output logic y);
    assign y = a ^ b;
endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU execute stage; multiply compiled in only with SEQ_ALU_MUL_EN.
// Latency: result valid one edge after accept, WIDTH edges for multiply.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);
    state_e state_q, state_d;
    logic   accept, is_mul, load_alu, load_mul, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] and_w, or_w, not_w, nor_w, nand_w, xor_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_err;
    logic [WIDTH:0]   sum_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gate_and2  u_and  (.a(a[i]), .b(b[i]), .y(and_w[i]));
        gate_or2   u_or   (.a(a[i]), .b(b[i]), .y(or_w[i]));
        gate_not1  u_not  (.a(a[i]),           .y(not_w[i]));
        gate_nor2  u_nor  (.a(a[i]), .b(b[i]), .y(nor_w[i]));
        gate_nand2 u_nand (.a(a[i]), .b(b[i]), .y(nand_w[i]));
        gate_xor2  u_xor  (.a(a[i]), .b(b[i]), .y(xor_w[i]));
    end

    assign sum_w = {1'b0, a} + {1'b0, b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_AND:  alu_res = and_w;
            OP_OR:   alu_res = or_w;
            OP_NOT:  alu_res = not_w;
            OP_NOR:  alu_res = nor_w;
            OP_NAND: alu_res = nand_w;
            OP_XOR:  alu_res = xor_w;
            OP_ADD:  {alu_carry, alu_res} = sum_w;
            OP_SUB: begin
                alu_res   = a - b;
                alu_carry = (a >= b);
            end
            default: alu_err = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    assign is_mul = (op == OP_MUL);

    alu_shift_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    mul_start = 1'b1;
                    state_d   = BUSY;
                end else if (accept) begin
                    load_alu = 1'b1;
                    state_d  = DONE;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            BUSY: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = DONE;
                end
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                result <= alu_res;
                carry  <= alu_carry;
                zero   <= !alu_err && (alu_res == '0);
                err    <= alu_err;
            end else if (load_mul) begin
                result <= mul_product[WIDTH-1:0];
                carry  <= |mul_product[2*WIDTH-1:WIDTH];
                zero   <= (mul_product[WIDTH-1:0] == '0);
                err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed plan cases plus random ops against an arithmetic model.
module tb_seq_alu;
    localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, carry, zero, err;
    logic [W-1:0] result;

    int total = 0;
    int passed = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: plain integer arithmetic on the opcode meanings.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic z, output logic e);
        longint unsigned xa = x;
        longint unsigned yb = y;
        longint unsigned full;
        longint unsigned modv = 64'd1 << W;
        r = '0; c = 1'b0; e = 1'b0;
        case (o)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = ~x;
            4'd3: r = ~(x | y);
            4'd4: r = ~(x & y);
            4'd5: r = x ^ y;
            4'd6: begin full = xa + yb; r = W'(full % modv); c = (full >= modv); end
            4'd7: begin full = (xa + modv - yb) % modv; r = W'(full); c = (xa >= yb); end
            4'd8: begin
                if (MUL_EN) begin full = xa * yb; r = W'(full % modv); c = (full >= modv); end
                else e = 1'b1;
            end
            default: e = 1'b1;
        endcase
        z = !e && (r == '0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        logic [W-1:0] er;
        logic ec, ez, ee;
        int cyc;
        int lat;
        model(o, x, y, er, ec, ez, ee);
        lat = (o == 4'd8 && MUL_EN) ? W : 0;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(lat));
        chk({tag, ".result"}, 32'(result), 32'(er));
        chk({tag, ".carry"}, 32'(carry), 32'(ec));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        chk({tag, ".err"}, 32'(err), 32'(ee));
        chk({tag, ".busy_rdy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 4'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            chk({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_res"}, 32'(result), 32'(er));
            chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".drain_vld"}, 32'(out_valid), 32'd0);
        chk({tag, ".drain_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state, including in_ready while reset is still asserted
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.flags", {29'd0, carry, zero, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.in_ready", 32'(in_ready), 32'd1);

        // out_ready while idle does nothing
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_ordy.vld", 32'(out_valid), 32'd0);

        run_op("and", 4'd0, 8'hF0, 8'h3C, 0);
        run_op("add_ovf", 4'd6, 8'hFF, 8'h01, 0);
        run_op("sub_brw", 4'd7, 8'h05, 8'h07, 0);
        run_op("sub_eq", 4'd7, 8'h33, 8'h33, 0);
        run_op("mul_a", 4'd8, 8'h0F, 8'h11, 0);
        run_op("mul_b", 4'd8, 8'h10, 8'h10, 0);
        run_op("mul_max", 4'd8, 8'hFF, 8'hFF, 0);
        run_op("xor_hold", 4'd5, 8'hAA, 8'h55, 3);
        run_op("illegal_a", 4'hA, 8'h12, 8'h34, 0);
        run_op("illegal_f", 4'hF, 8'h00, 8'h00, 0);

        // Reset pulsed during the 4th cycle of an operation (multiply, or DONE without it)
        op = 4'd8; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.vld", 32'(out_valid), 32'd0);
        chk("abort.res", 32'(result), 32'd0);
        chk("abort.rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("abort.no_late_vld", 32'(out_valid), 32'd0);
        chk("abort.rdy2", 32'(in_ready), 32'd1);
        run_op("not_after_rst", 4'd2, 8'h00, 8'h5A, 0);

        // Randomized ops with random output backpressure
        for (int n = 0; n < 40; n++) begin
            run_op("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU that succeeds the discrete gate library as the datapath execute stage. It accepts one operation at a time over a valid/ready input channel. Logic and add/subtract ops complete in one cycle; an optional shift-and-add multiply takes WIDTH cycles. The registered result is held on a valid/ready output channel until it is consumed.

## Interface
- WIDTH, 8, operand and result width in bits (minimum 2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- op  in  4  opcode (encoding below)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- carry  out  1  carry / not-borrow / multiply overflow
- zero  out  1  result equals 0
- err  out  1  illegal or disabled opcode

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 NOT a (b ignored), 3 NOR, 4 NAND, 5 XOR
  - 6 ADD, 7 SUB (a-b), 8 MUL
  - 9–15 illegal
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - Accept occurs when in_valid && in_ready at a clock edge.
- IDLE, non-MUL accept: compute combinationally, register result/carry/zero/err, go to DONE.
- IDLE, MUL accept: latch a and b, clear the 2·WIDTH accumulator, set bit counter to 0, go to BUSY.
- BUSY: each cycle, if multiplier bit[count] is 1, add (a << count) to the accumulator; increment count. After processing bit WIDTH-1, register the result and go to DONE.
- DONE: outputs are held stable. On out_valid && out_ready, go to IDLE. A new op cannot be accepted in the same cycle as the handshake.
- Arithmetic and flag rules:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: carry = 1 when a >= b (no borrow); result wraps modulo 2^WIDTH.
  - MUL: result = low WIDTH bits of the product; carry = OR of the high WIDTH bits.
  - Logic ops: carry = 0.
  - zero = (result == 0) for every legal op.
  - Illegal op: result = 0, carry = 0, zero = 0, err = 1, single-cycle path.
- in_valid while not IDLE: ignored, and the op is not captured.
- Operands and op need only be stable in the accept cycle.

## Timing
- Reset (async assert, sync release):
  - State → IDLE; out_valid, result, carry, zero, err, accumulator and counter → 0.
  - in_ready reads 1 while in reset and after release.
- Non-MUL latency: accept at edge k → out_valid = 1 after edge k.
- MUL latency: accept at edge k → BUSY for WIDTH cycles → out_valid = 1 after edge k+WIDTH.
- Maximum throughput with out_ready held high:
  - Non-MUL: one op per 2 cycles.
  - MUL: one op per WIDTH+2 cycles.
- Reset asserted mid-BUSY or in DONE aborts the op immediately; no partial result appears.
- out_ready asserted while not in DONE has no effect.

## Configuration
- SEQ_ALU_MUL_EN defined:
  - Opcode 8 performs the multiply; BUSY state, counter and alu_shift_mul are present.
- SEQ_ALU_MUL_EN undefined:
  - Opcode 8 is treated as illegal (err = 1, result 0, single-cycle path).
  - The BUSY state and the multiplier logic are not compiled.

## Structure
- Package seq_alu_pkg:
  - Opcode enum (4 bits, values above).
  - FSM state enum (IDLE, BUSY, DONE).
  - Constant OP_LAST_LEGAL = 8.
- Sub-module alu_shift_mul (compiled only under SEQ_ALU_MUL_EN):
  - Start/done interface.
  - Owns the accumulator and counter.
  - Parametrised by WIDTH.
- Logic ops are built from the existing AND/OR/NOT/NOR/NAND/XOR gate cells, replicated per bit with generate.

## Test plan
- WIDTH=8, AND a=0xF0 b=0x3C → result 0x30, zero 0, carry 0, out_valid one cycle after accept.
- ADD 0xFF+0x01 → result 0x00, carry 1, zero 1; then SUB 0x05−0x07 → result 0xFE, carry 0.
- MUL 0x0F×0x11 → result 0xFF, carry 0, out_valid 8 cycles after accept; then MUL 0x10×0x10 → result 0x00, carry 1, zero 1. Without the macro, opcode 8 → err 1, result 0.
- XOR 0xAA^0x55 with out_ready low for 3 cycles → result 0xFF held stable, in_ready 0, new in_valid ignored; out_ready high → IDLE, in_ready 1.
- rst_n pulsed low during cycle 4 of a MUL → out_valid 0, result 0, in_ready 1; a following NOT a=0x00 → result 0xFF.
- Opcode 0xA → err 1, result 0, zero 0, one-cycle latency.
